// File: rtl/dsm_mmd_ctrl.sv
// dsm_mmd_ctrl: fractional-N divider controller; each period loads N (+ DSM word) and counts it down.
// Build option: define DSM_MMD_FRAC_EN to add the DSM word to N, otherwise the block is integer-N only.
`ifndef DSM_MMD_ADDRESS
`define DSM_MMD_ADDRESS 32'h0000_0040
`endif

module dsm_mmd_ctrl #(
    parameter int D_MIN = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  i_dsm_data,
    output logic        o_dsm_take,
    output logic        o_div_pulse,
    output logic        o_div_clk,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [7:0]  i_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic [7:0]  o_wb_data
);
    localparam logic [31:0] CTRL_ADDR = `DSM_MMD_ADDRESS;
    localparam logic [31:0] STAT_ADDR = CTRL_ADDR + 32'd4;
    localparam logic signed [8:0] DMIN = 9'(D_MIN);

    logic [7:0] ctrl_q, ctrl_d, stat_q, stat_d, rdata_q, rdata_d;
    logic [7:0] cnt_q, cnt_d, d_q, d_d, d_eff;
    logic       ack_q, ack_d, pulse_q, pulse_d, clk_q, clk_d, en_prev_q;
    logic       wb_req, ctrl_hit, stat_hit, en_cur, en_nxt, load;
    logic signed [8:0] s;
`ifdef DSM_MMD_FRAC_EN
    logic       take_q, take_d;
`else
    logic       unused_dsm;
`endif

    // Bus decode: CTRL write, registered ack and read data.
    always_comb begin
        wb_req   = i_wb_cyc && i_wb_stb;
        ctrl_hit = i_wb_addr == CTRL_ADDR;
        stat_hit = i_wb_addr == STAT_ADDR;
        ack_d    = wb_req && (ctrl_hit || stat_hit);
        ctrl_d   = (wb_req && i_wb_we && ctrl_hit) ? i_wb_data : ctrl_q;
        rdata_d  = (wb_req && !i_wb_we) ? (ctrl_hit ? ctrl_q : stat_hit ? stat_q : 8'h00) : rdata_q;
    end

    // Effective ratio: N plus the signed DSM word, clamped from below.
    always_comb begin
`ifdef DSM_MMD_FRAC_EN
        s     = $signed({2'b00, ctrl_q[6:0]}) + $signed({{4{i_dsm_data[4]}}, i_dsm_data});
`else
        s     = $signed({2'b00, ctrl_q[6:0]});
`endif
        d_eff = (s < DMIN) ? DMIN[7:0] : s[7:0];
    end

    // Counter next state; outputs are precomputed from next state so they line up with cnt.
    always_comb begin
        en_cur  = ctrl_q[7];
        en_nxt  = ctrl_d[7];
        load    = en_cur && (cnt_q == 8'd0 || !en_prev_q);
        cnt_d   = !(en_cur && en_nxt) ? 8'd0 : load ? d_eff - 8'd1 : cnt_q - 8'd1;
        d_d     = load ? d_eff : d_q;
        pulse_d = en_nxt && en_cur && cnt_d == 8'd0;
        clk_d   = en_nxt && en_cur && cnt_d >= (d_d >> 1);
        stat_d  = stat_q + {7'd0, pulse_q};
`ifdef DSM_MMD_FRAC_EN
        take_d  = en_nxt && (cnt_d == 8'd0 || !en_cur);
`endif
    end

    // State and output flops; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q    <= '0;
            stat_q    <= '0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
            cnt_q     <= '0;
            d_q       <= '0;
            pulse_q   <= 1'b0;
            clk_q     <= 1'b0;
            en_prev_q <= 1'b0;
`ifdef DSM_MMD_FRAC_EN
            take_q    <= 1'b0;
`endif
        end else begin
            ctrl_q    <= ctrl_d;
            stat_q    <= stat_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
            cnt_q     <= cnt_d;
            d_q       <= d_d;
            pulse_q   <= pulse_d;
            clk_q     <= clk_d;
            en_prev_q <= en_cur;
`ifdef DSM_MMD_FRAC_EN
            take_q    <= take_d;
`endif
        end
    end

`ifdef DSM_MMD_FRAC_EN
    assign o_dsm_take = take_q;
`else
    assign o_dsm_take = 1'b0;
    assign unused_dsm = ^i_dsm_data;
`endif
    assign o_div_pulse = pulse_q;
    assign o_div_clk   = clk_q;
    assign o_wb_ack    = ack_q;
    assign o_wb_stall  = 1'b0;
    assign o_wb_data   = rdata_q;
endmodule

// File: tb/tb_dsm_mmd_ctrl.sv
// tb_dsm_mmd_ctrl: scoreboard bench for the fractional-N divider controller.
`ifndef DSM_MMD_ADDRESS
`define DSM_MMD_ADDRESS 32'h0000_0040
`endif

module tb_dsm_mmd_ctrl;
    localparam logic [31:0] CTRL = `DSM_MMD_ADDRESS;
    localparam logic [31:0] STAT = CTRL + 32'd4;
`ifdef DSM_MMD_FRAC_EN
    localparam bit FRAC = 1'b1;
`else
    localparam bit FRAC = 1'b0;
`endif

    logic        clk, reset, cyc, stb, we;
    logic [4:0]  dsm;
    logic [31:0] addr;
    logic [7:0]  wdat, o_wb_data;
    logic        o_dsm_take, o_div_pulse, o_div_clk, o_wb_ack, o_wb_stall;

    typedef struct {bit rd; logic [7:0] data;} wb_exp_t;
    int      exp_per[$];
    wb_exp_t wb_q[$];
    int      n_tests = 0, n_fail = 0, cyc_n = 0;

    dsm_mmd_ctrl dut (
        .clk(clk), .reset(reset), .i_dsm_data(dsm), .o_dsm_take(o_dsm_take),
        .o_div_pulse(o_div_pulse), .o_div_clk(o_div_clk), .i_wb_cyc(cyc), .i_wb_stb(stb),
        .i_wb_we(we), .i_wb_addr(addr), .i_wb_data(wdat), .o_wb_ack(o_wb_ack),
        .o_wb_stall(o_wb_stall), .o_wb_data(o_wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Caller is at a negedge; strobe is sampled on the following posedge.
    task automatic wb_write(input logic [31:0] a, input logic [7:0] v, input bit expect_ack);
        wb_exp_t e;
        e.rd = 1'b0;
        e.data = 8'h00;
        if (expect_ack) wb_q.push_back(e);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = a; wdat = v;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (!expect_ack) check("no_ack_wr", o_wb_ack, 0);
    endtask

    task automatic wb_read(input logic [31:0] a, input logic [7:0] v, input bit expect_ack);
        wb_exp_t e;
        e.rd = 1'b1;
        e.data = v;
        if (expect_ack) wb_q.push_back(e);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        if (!expect_ack) check("no_ack_rd", o_wb_ack, 0);
    endtask

    task automatic wait_pulses(input int k, input int budget);
        int seen = 0, t = 0;
        while (seen < k && t < budget) begin
            @(negedge clk);
            t++;
            if (o_div_pulse) seen++;
        end
        if (seen < k) check("pulse_timeout", seen, k);
    endtask

    task automatic count_pulses(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            if (o_div_pulse) c++;
        end
    endtask

    // Monitor: measures each period from div_clk rise to pulse and checks bus responses.
    initial begin : mon
        int rise_cyc, high, d;
        bit have_rise, prev_clk;
        wb_exp_t e;
        rise_cyc = 0; high = 0; have_rise = 0; prev_clk = 0;
        forever begin
            @(negedge clk);
            cyc_n++;
            if (!reset) begin
                have_rise = 0; prev_clk = 0; high = 0;
            end else begin
                if (o_div_clk && !prev_clk) begin
                    rise_cyc = cyc_n; high = 0; have_rise = 1;
                end
                if (o_div_clk) high++;
                prev_clk = o_div_clk;
                if (o_div_pulse) begin
                    if (exp_per.size() == 0) check("unexpected_pulse", o_div_pulse, 0);
                    else begin
                        d = exp_per.pop_front();
                        check("period_len", have_rise ? cyc_n - rise_cyc + 1 : 0, d);
                        check("clk_high", high, (d + 1) / 2);
                        check("take_at_pulse", o_dsm_take, FRAC);
                        have_rise = 0;
                    end
                end
                if (o_wb_ack) begin
                    if (wb_q.size() == 0) check("unexpected_ack", o_wb_ack, 0);
                    else begin
                        e = wb_q.pop_front();
                        if (e.rd) check("rd_data", o_wb_data, e.data);
                        else check("wr_stall", o_wb_stall, 0);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c;
        reset = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = 32'h0; wdat = 8'h0; dsm = 5'h00;
        repeat (3) @(negedge clk);
        check("rst_outs", {o_dsm_take, o_div_pulse, o_div_clk, o_wb_ack, o_wb_stall, o_wb_data}, 0);
        reset = 1'b1;
        @(negedge clk);
        // reset asserted mid-period clears everything asynchronously
        wb_write(CTRL, 8'h8A, 1);
        repeat (4) @(negedge clk);
        check("pre_rst_clk", o_div_clk, 1);
        #2 reset = 1'b0;
        #1 check("async_rst_outs", {o_dsm_take, o_div_pulse, o_div_clk, o_wb_ack, o_wb_data}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        wb_read(CTRL, 8'h00, 1);
        wb_read(STAT, 8'h00, 1);
        count_pulses(100, c);
        check("idle_pulses", c, 0);
        // integer N=10, STAT read in the pulse cycle sees the old value
        repeat (3) exp_per.push_back(10);
        wb_write(CTRL, 8'h8A, 1);
        wait_pulses(3, 60);
        wb_read(STAT, 8'd2, 1);
        wb_read(STAT, 8'd3, 1);
        // N=12 written mid-period applies from the next period
        exp_per.push_back(10);
        exp_per.push_back(12);
        exp_per.push_back(12);
        wb_write(CTRL, 8'h8C, 1);
        wait_pulses(3, 60);
        repeat (3) @(negedge clk);
        check("mid_clk_hi", o_div_clk, 1);
        wb_write(CTRL, 8'h0C, 1);
        check("dis_outs", {o_dsm_take, o_div_pulse, o_div_clk}, 0);
        count_pulses(30, c);
        check("dis_pulses", c, 0);
        wb_read(STAT, 8'd6, 1);
        wb_read(CTRL, 8'h0C, 1);
        // fractional sequence on N=20
        dsm = 5'h1D;
        if (FRAC) begin
            exp_per.push_back(17); exp_per.push_back(24); exp_per.push_back(20); exp_per.push_back(21);
        end else repeat (4) exp_per.push_back(20);
        wb_write(CTRL, 8'h94, 1);
        @(posedge clk);
        #1 dsm = 5'h04;
        wait_pulses(1, 200);
        @(posedge clk);
        #1 dsm = 5'h00;
        wait_pulses(1, 200);
        @(posedge clk);
        #1 dsm = 5'h01;
        wait_pulses(2, 200);
        wb_write(CTRL, 8'h14, 1);
        // clamp: N=5 with -3, N=2, N=127 with +15, N=10 with -16
        dsm = 5'h1D;
        repeat (2) exp_per.push_back(FRAC ? 4 : 5);
        wb_write(CTRL, 8'h85, 1);
        wait_pulses(2, 40);
        wb_write(CTRL, 8'h05, 1);
        dsm = 5'h00;
        repeat (2) exp_per.push_back(4);
        wb_write(CTRL, 8'h82, 1);
        wait_pulses(2, 40);
        wb_write(CTRL, 8'h02, 1);
        dsm = 5'h0F;
        exp_per.push_back(FRAC ? 142 : 127);
        wb_write(CTRL, 8'hFF, 1);
        wait_pulses(1, 300);
        wb_write(CTRL, 8'h7F, 1);
        dsm = 5'h10;
        exp_per.push_back(FRAC ? 4 : 10);
        wb_write(CTRL, 8'h8A, 1);
        wait_pulses(1, 40);
        wb_write(CTRL, 8'h0A, 1);
        // bus: unmapped accesses get no ack, STAT writes are acked and ignored
        wb_read(CTRL + 32'd8, 8'h00, 0);
        wb_write(CTRL + 32'd1, 8'hFF, 0);
        wb_read(CTRL, 8'h0A, 1);
        wb_write(STAT, 8'hAA, 1);
        wb_read(STAT, 8'd16, 1);
        repeat (2) @(negedge clk);
        check("sb_per_empty", exp_per.size(), 0);
        check("sb_wb_empty", wb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
